// File: rtl/bus_slot_pkg.sv
// Shared definitions for the bus slot scheduler.
// Holds the phase values that bound the two bus slots within one 64-clock CPU cycle,
// and the owner type used to record which master holds the bus in the current slot.
package bus_slot_pkg;

  // Slot A covers phases 0..31 and slot B covers 33..62. Phases 32 and 63 are the
  // non-overlap gaps where nobody owns the bus.
  localparam int unsigned SLOT_A_START = 0;
  localparam int unsigned SLOT_A_END   = 31;
  localparam int unsigned SLOT_B_START = 33;
  localparam int unsigned SLOT_B_END   = 62;
  localparam int unsigned PH_LAST      = 63;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CPU  = 2'd1,
    AVG  = 2'd2,
    HOST = 2'd3
  } owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter.
// The grant outputs are combinational and always reflect who would win right now; the
// caller captures them on the cycle it raises decide_i. The priority pointer moves only
// when decide_i sees both requests, so uncontested grants leave fairness untouched.
//   clk_i, rst_ni      clock and asynchronous active-low reset (pointer favours a)
//   decide_i           the caller is latching the result this clock
//   req_a_i, req_b_i   requests
//   gnt_a_o, gnt_b_o   one-hot (or zero) winner
module rr_arb2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic decide_i,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  // 0: a has priority on a tie, 1: b has priority.
  logic ptr_q, ptr_d;

  assign gnt_a_o = req_a_i & (~req_b_i | ~ptr_q);
  assign gnt_b_o = req_b_i & (~req_a_i | ptr_q);

  always_comb begin
    ptr_d = ptr_q;
    if (decide_i && req_a_i && req_b_i) begin
      ptr_d = ~ptr_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/bus_slot_sched.sv
// CPU clock-phase generator and bus slot scheduler.
// A free-running phase counter divides the 96 MHz clock into 64-clock CPU cycles. It yields
// the 12 MHz / 6 MHz enables, the two-phase CPU clock levels and the CPU cycle strobe, and
// splits each cycle into two bus slots: slot A is always arbitrated between the vector
// generator and the host; slot B belongs to the CPU unless it is halted, in which case slot B
// is arbitrated too. Halt requests take effect only on a CPU cycle boundary.
//   clk_96MHz, reset_n   system clock, asynchronous active-low reset
//   halt_req             stop the CPU at the next cycle boundary (level)
//   avg_req, host_req    bus requests (level), sampled only at slot decision points
//   ce_12m, ce_6m        one-clock enables every 8 / 16 clocks
//   phi1, phi2           non-overlapping CPU phase levels
//   cpu_ce               one-clock CPU cycle-advance strobe at phase 63
//   halt_ack             CPU is halted
//   cpu_own, gnt_avg, gnt_host   bus owner for the current slot (at most one high)
module bus_slot_sched
  import bus_slot_pkg::*;
#(
  parameter int unsigned PH_BITS = 6
) (
  input  logic clk_96MHz,
  input  logic reset_n,
  input  logic halt_req,
  input  logic avg_req,
  input  logic host_req,
  output logic ce_12m,
  output logic ce_6m,
  output logic phi1,
  output logic phi2,
  output logic cpu_ce,
  output logic halt_ack,
  output logic cpu_own,
  output logic gnt_avg,
  output logic gnt_host
);

  localparam logic [PH_BITS-1:0] PhAStart = PH_BITS'(SLOT_A_START);
  localparam logic [PH_BITS-1:0] PhAEnd   = PH_BITS'(SLOT_A_END);
  localparam logic [PH_BITS-1:0] PhAGap   = PH_BITS'(SLOT_A_END + 1);
  localparam logic [PH_BITS-1:0] PhBStart = PH_BITS'(SLOT_B_START);
  localparam logic [PH_BITS-1:0] PhBEnd   = PH_BITS'(SLOT_B_END);
  localparam logic [PH_BITS-1:0] PhLast   = PH_BITS'(PH_LAST);

  logic [PH_BITS-1:0] ph_q, ph_d;
  logic               halted_q, halted_d;
  owner_e             owner_q, owner_d, arb_owner;
  logic               ce_12m_q, ce_12m_d;
  logic               ce_6m_q, ce_6m_d;
  logic               phi1_q, phi1_d;
  logic               phi2_q, phi2_d;
  logic               cpu_ce_q, cpu_ce_d;
  logic               decide, win_avg, win_host;

  // All registered outputs are computed from the next phase so they line up with ph_q.
  assign ph_d = ph_q + PH_BITS'(1);

  // Halt is only looked at on the edge that closes a CPU cycle.
  assign halted_d = (ph_q == PhLast) ? halt_req : halted_q;

  // Slot B is only contested while the CPU is halted; halted_q cannot change on this edge.
  assign decide = (ph_d == PhAStart) | ((ph_d == PhBStart) & halted_q);

  rr_arb2 u_arb (
    .clk_i    (clk_96MHz),
    .rst_ni   (reset_n),
    .decide_i (decide),
    .req_a_i  (avg_req),
    .req_b_i  (host_req),
    .gnt_a_o  (win_avg),
    .gnt_b_o  (win_host)
  );

  always_comb begin
    arb_owner = NONE;
    if (win_avg) begin
      arb_owner = AVG;
    end else if (win_host) begin
      arb_owner = HOST;
    end

    // Owner is held for the whole slot; late requests or drops mid-slot are ignored.
    owner_d = owner_q;
    if (ph_d == PhAStart) begin
      owner_d = arb_owner;
    end else if (ph_d == PhBStart) begin
      owner_d = halted_q ? arb_owner : CPU;
    end else if ((ph_d == PhAGap) || (ph_d == PhLast)) begin
      owner_d = NONE;
    end
  end

  always_comb begin
    ce_12m_d = &ph_d[2:0];
    ce_6m_d  = &ph_d[3:0];
    phi1_d   = (ph_d <= PhAEnd);
    phi2_d   = (ph_d >= PhBStart) && (ph_d <= PhBEnd);
    // A halting CPU still completes its last cycle; a resuming one gets no strobe.
    cpu_ce_d = (ph_d == PhLast) && !halted_q;
  end

  always_ff @(posedge clk_96MHz or negedge reset_n) begin
    if (!reset_n) begin
      ph_q     <= '0;
      halted_q <= 1'b0;
      owner_q  <= NONE;
      ce_12m_q <= 1'b0;
      ce_6m_q  <= 1'b0;
      phi1_q   <= 1'b0;
      phi2_q   <= 1'b0;
      cpu_ce_q <= 1'b0;
    end else begin
      ph_q     <= ph_d;
      halted_q <= halted_d;
      owner_q  <= owner_d;
      ce_12m_q <= ce_12m_d;
      ce_6m_q  <= ce_6m_d;
      phi1_q   <= phi1_d;
      phi2_q   <= phi2_d;
      cpu_ce_q <= cpu_ce_d;
    end
  end

  assign ce_12m   = ce_12m_q;
  assign ce_6m    = ce_6m_q;
  assign phi1     = phi1_q;
  assign phi2     = phi2_q;
  assign cpu_ce   = cpu_ce_q;
  assign halt_ack = halted_q;
  // Decoding a single owner register keeps the three grants mutually exclusive.
  assign cpu_own  = (owner_q == CPU);
  assign gnt_avg  = (owner_q == AVG);
  assign gnt_host = (owner_q == HOST);

endmodule

// File: doc/bus_slot_sched.md
BUS_SLOT_SCHED -- requirements
Module: bus_slot_sched

Interface
REQ-001 SHALL have parameter PH_BITS, default 6, meaning width of the phase counter (one CPU cycle = 2^PH_BITS clocks = 64 clocks of 96 MHz, i.e. 1.5 MHz).
REQ-002 SHALL have port clk_96MHz  in  1  the single system clock; all logic on its rising edge.
REQ-003 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port halt_req  in  1  request to stop the CPU at the next cycle boundary.
REQ-005 SHALL have port avg_req  in  1  vector-generator bus request (level).
REQ-006 SHALL have port host_req  in  1  host/loader bus request (level).
REQ-007 SHALL have port ce_12m  out  1  one-clock enable pulse every 8 clocks.
REQ-008 SHALL have port ce_6m  out  1  one-clock enable pulse every 16 clocks.
REQ-009 SHALL have port phi1  out  1  CPU phase-1 level.
REQ-010 SHALL have port phi2  out  1  CPU phase-2 level.
REQ-011 SHALL have port cpu_ce  out  1  one-clock CPU cycle-advance strobe.
REQ-012 SHALL have port halt_ack  out  1  CPU is halted.
REQ-013 SHALL have port cpu_own  out  1  CPU owns the bus.
REQ-014 SHALL have port gnt_avg  out  1  vector generator owns the bus.
REQ-015 SHALL have port gnt_host  out  1  host owns the bus.

Function
REQ-016 SHALL keep phase counter ph, incrementing every clock, wrapping 63->0, never stalled by halt.
REQ-017 SHALL drive ce_12m = 1 only when ph[2:0]==7 and ce_6m = 1 only when ph[3:0]==15, both registered.
REQ-018 SHALL drive phi1 = 1 for ph 0..31 and phi2 = 1 for ph 33..62; both 0 at ph 32 and 63 (non-overlap gaps), both registered.
REQ-019 SHALL pulse cpu_ce at ph==63 when halted==0, or when halted==0 is about to become 1 (the last cycle completes).
REQ-020 SHALL sample halt_req only at ph==63: halted 0->1 if halt_req=1; halted 1->0 if halt_req=0; cpu_ce is suppressed on the resuming boundary; halt_ack = halted.
REQ-021 SHALL make slot A = ph 0..31, slot B = ph 33..62; no owner at ph 32 or 63.
REQ-022 SHALL assert cpu_own throughout slot B while halted==0.
REQ-023 SHALL arbitrate slot A at ph==0 from avg_req/host_req sampled that clock, and slot B at ph==33 likewise when halted==1.
REQ-024 SHALL hold the decided grant for the whole slot, ignoring request drop mid-slot, and clear it at slot end.
REQ-025 SHALL use two-way round-robin: when both request, the requester not granted last wins; the priority pointer updates only on a contested grant; pointer reset favours avg.
REQ-026 SHALL keep cpu_own, gnt_avg and gnt_host mutually exclusive at every clock (at most one high).
REQ-027 SHALL leave the slot unowned if no request is sampled at its decision point; late requests wait for the next decision.

Reset
REQ-028 SHALL on reset_n=0 asynchronously clear ph, halted, all grants, ce_12m, ce_6m, cpu_ce, phi1, phi2 to 0 and set the priority pointer to avg.
REQ-029 SHALL restart at ph=0 after reset release, with the first decision at the first ph==0 edge after release; reset mid-slot revokes grants immediately.

Structure
REQ-030 SHALL take slot boundary constants (SLOT_A_START=0, SLOT_A_END=31, SLOT_B_START=33, SLOT_B_END=62, PH_LAST=63) and an owner enum (NONE, CPU, AVG, HOST) from a shared package, bus_slot_pkg.
REQ-031 SHALL instantiate one sub-module, rr_arb2 (2-input round-robin with decide strobe), for both slots.

Verification
REQ-032 SHALL verify reset release, no requests -> ce_12m at ph 7,15,..., ce_6m at ph 15,31,47,63, phi1 high for 32 clocks, phi2 for 30 clocks, cpu_ce once per 64 clocks.
REQ-033 SHALL verify avg_req=1 constantly, host_req=0 -> gnt_avg high ph 0..31 every cycle; cpu_own high ph 33..62.
REQ-034 SHALL verify avg_req=host_req=1 constantly -> slot A grants alternate AVG, HOST, AVG, ... over 4 cycles.
REQ-035 SHALL verify halt_req=1 at ph 63 -> cpu_ce still pulses that clock; halt_ack=1 from ph 0; slot B then granted to requester; halt_req=0 -> resume with no cpu_ce on the boundary and cpu_own in the next slot B.
REQ-036 SHALL verify host_req rising at ph 5 -> no grant until the next ph 0 (or ph 33 if halted); avg_req dropping at ph 10 -> gnt_avg held to ph 31.
REQ-037 SHALL verify reset_n pulsed low at ph 20 with gnt_host=1 -> all outputs 0 asynchronously; pointer back to avg.
